// File: rtl/layer_sequencer_if.sv
// Engine-array / scratch-RAM bundle for the layer sequencer.
// The master side is the sequencer. The slave side is the engine array together with the scratch RAM.
interface layer_sequencer_if #(
    parameter int NUM_LAYERS = 5
);
    logic [NUM_LAYERS-1:0]    eng_start;
    logic [NUM_LAYERS-1:0]    eng_ready;
    logic [NUM_LAYERS*14-1:0] eng_addr;
    logic [NUM_LAYERS*32-1:0] eng_data;
    logic [NUM_LAYERS-1:0]    eng_wren;
    logic [13:0]              mem_addr;
    logic signed [31:0]       mem_data;
    logic                     mem_wren;

    modport master (
        output eng_start, mem_addr, mem_data, mem_wren,
        input  eng_ready, eng_addr, eng_data, eng_wren
    );

    modport slave (
        input  eng_start, mem_addr, mem_data, mem_wren,
        output eng_ready, eng_addr, eng_data, eng_wren
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer sequencer: launches the layer engines one at a time and watches each with a timeout.
// It gives the scratch RAM port to whichever engine is active.
module layer_sequencer #(
    parameter int NUM_LAYERS = 5,
    parameter int TIMEOUT    = 1048576
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               run,
    layer_sequencer_if.master  bus,
    output logic [2:0]         active_layer,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]     LAST_LAYER = 3'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT, ADVANCE, FINISH, FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    layer, layer_nxt;
    logic [TW-1:0] timer, timer_nxt;

    // State, layer index and watchdog timer registers; only control state is reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            layer <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            layer <= layer_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state logic. The active engine's ready wins over an expiring timer in the same cycle.
    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                layer_nxt = '0;
                timer_nxt = '0;
                if (run) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                timer_nxt = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                timer_nxt = timer + TW'(1);
                if (bus.eng_ready[layer])
                    state_nxt = ADVANCE;
                else if (timer == TIMER_LAST)
                    state_nxt = FAULT;
            end
            ADVANCE: begin
                if (layer == LAST_LAYER) begin
                    state_nxt = FINISH;
                end else begin
                    layer_nxt = layer + 3'd1;
                    state_nxt = LAUNCH;
                end
            end
            FINISH: begin
                layer_nxt = '0;
                state_nxt = IDLE;
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // Start pulse and RAM mux. Only the active engine's write enable passes, and only while it runs.
    always_comb begin
        bus.eng_start = '0;
        if (state == LAUNCH) bus.eng_start[layer] = 1'b1;
        bus.mem_addr = bus.eng_addr[layer*14 +: 14];
        bus.mem_data = $signed(bus.eng_data[layer*32 +: 32]);
        bus.mem_wren = (state == WAIT) && bus.eng_wren[layer];
    end

    assign active_layer = layer;
    assign busy         = (state != IDLE) && (state != FAULT);
    assign done         = (state == FINISH);
    assign error        = (state == FAULT);
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: it drives directed scenarios with model engines that answer after a set latency.
// A chain-level reference model is compared every cycle, and hand-computed timing checks pin the reference model.
module tb_layer_sequencer;
    localparam int NL = 5;
    localparam int TO = 64;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       run = 1'b0;
    logic [2:0] active_layer;
    logic       busy, done, error;

    layer_sequencer_if #(.NUM_LAYERS(NL)) bus();

    layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .run(run), .bus(bus),
        .active_layer(active_layer), .busy(busy), .done(done), .error(error)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // chain-level reference: mode, current layer, cycles since its start pulse, advance pending
    int m_mode = M_IDLE;
    int m_layer = 0;
    int m_t = 0;
    bit m_adv = 1'b0;
    bit mvalid = 1'b0;

    int lat[NL];
    int ready_due[NL] = '{default: -1};
    logic [NL-1:0] extra_rdy = '0;
    int st_idx[$];
    int st_cyc[$];
    int done_q[$];
    int err_cyc = -1;
    int wr1_cnt = 0;

    logic [NL-1:0] e_start;
    logic          e_wren;
    logic [57:0]   e_vec, a_vec;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference model advances on the same edge as the DUT
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (Reset) begin
            m_mode <= M_IDLE; m_layer <= 0; m_t <= 0; m_adv <= 1'b0; mvalid <= 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_layer <= 0;
                    if (run) begin m_mode <= M_RUN; m_t <= 0; m_adv <= 1'b0; end
                end
                M_RUN: begin
                    if (m_adv) begin
                        if (m_layer == NL - 1) m_mode <= M_DONE;
                        else begin m_layer <= m_layer + 1; m_t <= 0; m_adv <= 1'b0; end
                    end else if (m_t == 0) m_t <= 1;
                    else if (bus.eng_ready[m_layer]) m_adv <= 1'b1;
                    else if (m_t == TO) m_mode <= M_FAULT;
                    else m_t <= m_t + 1;
                end
                M_DONE: begin m_mode <= M_IDLE; m_layer <= 0; end
                default: ;
            endcase
        end
    end

    // compare every output against the reference on the falling edge and log events
    always @(negedge Clk) begin
        if (mvalid) begin
            e_start = '0;
            if (m_mode == M_RUN && !m_adv && m_t == 0) e_start[m_layer] = 1'b1;
            e_wren = (m_mode == M_RUN) && !m_adv && (m_t >= 1) && bus.eng_wren[m_layer];
            e_vec = {e_start, (m_mode == M_RUN || m_mode == M_DONE), (m_mode == M_DONE),
                     (m_mode == M_FAULT), 3'(m_layer), e_wren,
                     bus.eng_addr[m_layer*14 +: 14], bus.eng_data[m_layer*32 +: 32]};
            a_vec = {bus.eng_start, busy, done, error, active_layer, bus.mem_wren,
                     bus.mem_addr, bus.mem_data};
            checks++;
            if (a_vec !== e_vec) begin
                errors++;
                $display("FAIL cycle_compare: got %h, expected %h (cycle %0d)", a_vec, e_vec, cyc);
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (bus.eng_start[i]) begin
                st_idx.push_back(i);
                st_cyc.push_back(cyc);
                ready_due[i] = (lat[i] < 0) ? -1 : cyc + lat[i];
            end
        end
        if (done) done_q.push_back(cyc);
        if (error && err_cyc < 0) err_cyc = cyc;
        if (bus.mem_wren && active_layer == 3'd1 && bus.mem_addr == 14'h0C4 &&
            $signed(bus.mem_data) == -32'sd7) wr1_cnt++;
        if (Reset) for (int i = 0; i < NL; i++) ready_due[i] = -1;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        for (int i = 0; i < NL; i++)
            bus.eng_ready[i] = (ready_due[i] == cyc) || extra_rdy[i];
    endtask

    function automatic int probe(input int w);
        case (w)
            0:       return done_q.size();
            1:       return st_idx.size();
            default: return (err_cyc >= 0) ? 1 : 0;
        endcase
    endfunction

    task automatic wait_for(input int w, input int target, input int bound, input string nm);
        int k = 0;
        while (probe(w) < target && k < bound) begin tick(); k++; end
        chk(nm, (probe(w) >= target) ? 1 : 0, 1);
    endtask

    task automatic clear_logs();
        st_idx.delete(); st_cyc.delete(); done_q.delete();
    endtask

    task automatic pulse_run();
        run = 1'b1; tick(); run = 1'b0;
    endtask

    initial begin
        bus.eng_ready = '0;
        bus.eng_wren  = '0;
        for (int i = 0; i < NL; i++) begin
            lat[i] = 10;
            bus.eng_addr[i*14 +: 14] = 14'(i*256 + 5);
            bus.eng_data[i*32 +: 32] = 32'(i*1000 - 3);
        end
        bus.eng_addr[14 +: 14] = 14'h0C4;
        bus.eng_data[32 +: 32] = 32'hFFFF_FFF9;

        // reset state
        Reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_active", active_layer, 0);
        chk("rst_start", bus.eng_start, 0);
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_mem_addr", bus.mem_addr, 5);
        chk("rst_mem_data", $signed(bus.mem_data), -3);
        Reset = 1'b0;
        tick();

        // nominal chain with RAM arbitration and a spurious ready from engine 2
        clear_logs();
        bus.eng_wren = NL'(5'b01010);
        pulse_run();
        tick(); tick();
        extra_rdy = NL'(5'b00100);
        tick();
        extra_rdy = '0;
        wait_for(0, 1, 200, "nom_done_timeout");
        chk("nom_start_count", st_idx.size(), 5);
        for (int i = 0; i < NL && i < st_idx.size(); i++) chk("nom_start_order", st_idx[i], i);
        for (int i = 1; i < NL && i < st_cyc.size(); i++)
            chk("nom_start_spacing", st_cyc[i] - st_cyc[i-1], 12);
        if (st_cyc.size() == NL && done_q.size() > 0)
            chk("nom_done_time", done_q[0] - st_cyc[NL-1], 12);
        chk("nom_error", error, 0);
        chk("nom_wr1_cycles", wr1_cnt, 10);
        bus.eng_wren = '0;
        repeat (3) tick();

        // boundary: ready in the same cycle the timer reaches its limit
        clear_logs();
        lat[0] = TO;
        pulse_run();
        wait_for(0, 1, 400, "bnd_done_timeout");
        chk("bnd_error", error, 0);
        if (st_cyc.size() >= 2) chk("bnd_gap", st_cyc[1] - st_cyc[0], TO + 2);
        lat[0] = 10;
        repeat (3) tick();

        // timeout: engine 1 never answers
        clear_logs();
        lat[1] = -1;
        pulse_run();
        wait_for(2, 1, 300, "to_error_timeout");
        if (st_cyc.size() >= 2) chk("to_fault_time", err_cyc - st_cyc[1], TO + 1);
        run = 1'b1;
        repeat (20) tick();
        run = 1'b0;
        chk("to_no_more_starts", st_idx.size(), 2);
        chk("to_error_sticky", error, 1);
        chk("to_busy", busy, 0);
        chk("to_no_done", done_q.size(), 0);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("to_error_cleared", error, 0);
        lat[1] = 10;
        err_cyc = -1;
        tick();

        // reset in the middle of layer 3
        clear_logs();
        pulse_run();
        wait_for(1, 4, 200, "mid_reach_l3");
        repeat (3) tick();
        chk("mid_active_before", active_layer, 3);
        chk("mid_busy_before", busy, 1);
        Reset = 1'b1; tick();
        chk("mid_active_after", active_layer, 0);
        chk("mid_busy_after", busy, 0);
        chk("mid_start_after", bus.eng_start, 0);
        Reset = 1'b0;
        repeat (30) tick();
        chk("mid_no_more_starts", st_idx.size(), 4);
        chk("mid_no_done", done_q.size(), 0);
        clear_logs();
        pulse_run();
        wait_for(0, 1, 200, "mid_rerun_timeout");
        if (st_idx.size() > 0) chk("mid_rerun_first", st_idx[0], 0);
        chk("mid_rerun_count", st_idx.size(), 5);
        repeat (3) tick();

        // back-to-back chains with run held high
        clear_logs();
        run = 1'b1;
        wait_for(0, 2, 400, "b2b_timeout");
        run = 1'b0;
        if (st_idx.size() > 5 && done_q.size() > 0) begin
            chk("b2b_second_first", st_idx[5], 0);
            chk("b2b_restart_time", st_cyc[5] - done_q[0], 2);
        end else begin
            chk("b2b_second_chain", st_idx.size(), 10);
        end
        repeat (5) tick();
        chk("b2b_idle", busy, 0);
        chk("b2b_start_total", st_idx.size(), 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
